// File: rtl/apb_i2c_pkg.sv
// Shared definitions for the APB front-end of the I2C bridge:
// register byte offsets, CON1/INT bit positions, speed codes and the
// APB phase-tracking state type.
package apb_i2c_pkg;

    // Register byte offsets (word aligned)
    localparam logic [31:0] OFF_CON1 = 32'h00;
    localparam logic [31:0] OFF_CON2 = 32'h04;
    localparam logic [31:0] OFF_TX   = 32'h08;
    localparam logic [31:0] OFF_RX   = 32'h0C;
    localparam logic [31:0] OFF_STAT = 32'h10;
    localparam logic [31:0] OFF_INT  = 32'h14;

    // CON1 bit positions
    localparam int CON1_SRST    = 0;
    localparam int CON1_EN      = 1;
    localparam int CON1_BYT_LSB = 2;
    localparam int CON1_DA      = 4;
    localparam int CON1_REP     = 5;
    localparam int CON1_SPD_LSB = 6;

    // INT bit positions
    localparam int INT_DONE = 0;
    localparam int INT_TMO  = 1;
    localparam int INT_IE   = 8;

    // Speed codes for CON1[7:6]
    localparam logic [1:0] SPD_STD   = 2'b00;
    localparam logic [1:0] SPD_FAST  = 2'b01;
    localparam logic [1:0] SPD_FASTP = 2'b10;
    localparam logic [1:0] SPD_HIGH  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } apb_state_e;

endpackage

// File: rtl/apb_i2c_seq.sv
// Bridge sequencing: owns CON1, the one-shot enable with its start
// timeout, the soft-reset hold counter, and done capture on the rising
// edge of the bridge ready.
//   clk_i, rst_ni      clock / async active-low reset
//   ready_i, dout_i    bridge idle flag and RX word
//   con1_wr_i          full CON1 write accepted (bridge idle)
//   con1_wdata_i       CON1 write data bits [7:1]
//   srst_wr_i          CON1 write with bit0=1 (full or busy-time partial)
//   int_w1c_i          INT write-one-to-clear strobes {timeout, done}
//   con1_o             CON1 value driven to the bridge
//   rx_o               captured RX word
//   done_o, tmo_o      interrupt flags
module apb_i2c_seq
    import apb_i2c_pkg::*;
#(
    parameter int RST_HOLD = 16,
    parameter int START_TO = 4096
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        ready_i,
    input  logic [31:0] dout_i,
    input  logic        con1_wr_i,
    input  logic [7:1]  con1_wdata_i,
    input  logic        srst_wr_i,
    input  logic [1:0]  int_w1c_i,
    output logic [7:0]  con1_o,
    output logic [31:0] rx_o,
    output logic        done_o,
    output logic        tmo_o
);

    localparam int                TO_W      = $clog2(START_TO + 1);
    localparam logic [TO_W-1:0]   TO_LOAD   = TO_W'(START_TO);
    localparam logic [7:0]        HOLD_LOAD = 8'(RST_HOLD);

    logic [7:0]      hold_q, hold_d;
    logic [7:2]      cfg_q, cfg_d;
    logic            en_q, en_d;
    logic [TO_W-1:0] to_q, to_d;
    logic            ready_q;
    logic [31:0]     rx_q, rx_d;
    logic            done_q, done_d;
    logic            tmo_q, tmo_d;

    logic srst_act;
    logic block_en;
    logic tmo_set;
    logic rise;

    always_comb begin
        hold_d = hold_q;
        if (srst_wr_i) begin
            hold_d = HOLD_LOAD;
        end else if (hold_q != 8'd0) begin
            hold_d = hold_q - 8'd1;
        end

        srst_act = (hold_q != 8'd0);
        // A soft-reset write also kills enable on its own edge, so the
        // bridge never sees enable together with soft reset.
        block_en = srst_act | srst_wr_i;

        cfg_d = cfg_q;
        if (con1_wr_i) begin
            cfg_d = con1_wdata_i[7:2];
        end

        en_d    = en_q;
        to_d    = to_q;
        tmo_set = 1'b0;
        if (block_en) begin
            en_d = 1'b0;
            to_d = '0;
        end else if (en_q) begin
            if (!ready_i) begin
                // Bridge picked up the command: one-shot enable done.
                en_d = 1'b0;
                to_d = '0;
            end else if (to_q <= TO_W'(1)) begin
                en_d    = 1'b0;
                to_d    = '0;
                tmo_set = 1'b1;
            end else begin
                to_d = to_q - TO_W'(1);
            end
        end else if (con1_wr_i && con1_wdata_i[CON1_EN]) begin
            en_d = 1'b1;
            to_d = TO_LOAD;
        end

        rise   = !ready_q && ready_i && !srst_act;
        rx_d   = rise ? dout_i : rx_q;
        // Set has priority over a coincident write-one-to-clear.
        done_d = rise    | (done_q & ~int_w1c_i[INT_DONE]);
        tmo_d  = tmo_set | (tmo_q  & ~int_w1c_i[INT_TMO]);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hold_q  <= '0;
            cfg_q   <= '0;
            en_q    <= 1'b0;
            to_q    <= '0;
            ready_q <= 1'b1;
            rx_q    <= '0;
            done_q  <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            hold_q  <= hold_d;
            cfg_q   <= cfg_d;
            en_q    <= en_d;
            to_q    <= to_d;
            ready_q <= ready_i;
            rx_q    <= rx_d;
            done_q  <= done_d;
            tmo_q   <= tmo_d;
        end
    end

    assign con1_o = {cfg_q, en_q, srst_act};
    assign rx_o   = rx_q;
    assign done_o = done_q;
    assign tmo_o  = tmo_q;

endmodule

// File: rtl/apb_i2c_regs.sv
// APB3 slave register block in front of the I2C bridge.
//   PCLK, PRESETn             clock / async active-low reset
//   PSEL..PWDATA              APB request
//   PRDATA, PREADY, PSLVERR   APB response (zero wait states)
//   i2c_con1, i2c_con2, Din   control bytes and TX word to the bridge
//   Dout, i2c_stat, ready     RX word, status and idle flag from the bridge
//   irq                       level interrupt
// PRDATA/PSLVERR are registered at the end of the setup phase so they are
// valid throughout the access phase and zero otherwise; registers commit
// on the edge that ends the access phase.
module apb_i2c_regs
    import apb_i2c_pkg::*;
#(
    parameter int ADDR_W   = 5,
    parameter int RST_HOLD = 16,
    parameter int START_TO = 4096
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [ADDR_W-1:0] PADDR,
    input  logic [31:0]       PWDATA,
    output logic [31:0]       PRDATA,
    output logic              PREADY,
    output logic              PSLVERR,
    output logic [7:0]        i2c_con1,
    output logic [7:0]        i2c_con2,
    output logic [31:0]       Din,
    input  logic [31:0]       Dout,
    input  logic [7:0]        i2c_stat,
    input  logic              ready,
    output logic              irq
);

    apb_state_e  state_q, state_d;
    logic [7:0]  con2_q, con2_d;
    logic [31:0] din_q, din_d;
    logic        ie_q, ie_d;
    logic [31:0] prdata_q, prdata_d;
    logic        slverr_q, slverr_d;
    logic        irq_q, irq_d;

    logic [31:0] addr;
    logic        sel_con1, sel_con2, sel_tx, sel_rx, sel_stat, sel_int;
    logic        mapped, busy, err;
    logic        setup_ph, commit, wr_ok;
    logic        con1_wr, srst_wr;
    logic [1:0]  int_w1c;
    logic [31:0] rd_mux;
    logic [31:0] rx_w;
    logic        done_w, tmo_w;

    // APB phase tracking
    always_comb begin
        state_d = ST_IDLE;
        if (PSEL && !PENABLE) begin
            state_d = ST_SETUP;
        end else if (PSEL && PENABLE && state_q == ST_SETUP) begin
            state_d = ST_ACCESS;
        end
    end

    always_comb begin
        addr     = 32'(PADDR);
        sel_con1 = (addr == OFF_CON1);
        sel_con2 = (addr == OFF_CON2);
        sel_tx   = (addr == OFF_TX);
        sel_rx   = (addr == OFF_RX);
        sel_stat = (addr == OFF_STAT);
        sel_int  = (addr == OFF_INT);
        mapped   = sel_con1 | sel_con2 | sel_tx | sel_rx | sel_stat | sel_int;
        busy     = !ready | i2c_con1[CON1_EN];

        // A busy-time CON1 write carrying bit0=1 is accepted as a pure
        // soft-reset request.
        err = !mapped
            | (PWRITE & (sel_rx | sel_stat))
            | (PWRITE & (sel_con2 | sel_tx) & busy)
            | (PWRITE & sel_con1 & busy & !PWDATA[CON1_SRST]);

        setup_ph = (state_d == ST_SETUP);
        commit   = (state_d == ST_ACCESS);
        wr_ok    = commit & PWRITE & !err;
        con1_wr  = wr_ok & sel_con1 & !busy;
        srst_wr  = wr_ok & sel_con1 & PWDATA[CON1_SRST];
        int_w1c  = (wr_ok & sel_int) ? PWDATA[1:0] : 2'b00;

        con2_d = con2_q;
        din_d  = din_q;
        ie_d   = ie_q;
        if (wr_ok && sel_con2) con2_d = PWDATA[7:0];
        if (wr_ok && sel_tx)   din_d  = PWDATA;
        if (wr_ok && sel_int)  ie_d   = PWDATA[INT_IE];

        rd_mux = '0;
        if (sel_con1) rd_mux = {24'd0, i2c_con1};
        if (sel_con2) rd_mux = {24'd0, con2_q};
        if (sel_tx)   rd_mux = din_q;
        if (sel_rx)   rd_mux = rx_w;
        if (sel_stat) rd_mux = {23'd0, ready, i2c_stat};
        if (sel_int)  rd_mux = {23'd0, ie_q, 6'd0, tmo_w, done_w};

        prdata_d = (setup_ph && !PWRITE) ? rd_mux : 32'd0;
        slverr_d = setup_ph & err;
        irq_d    = ie_q & (done_w | tmo_w);
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q  <= ST_IDLE;
            con2_q   <= '0;
            din_q    <= '0;
            ie_q     <= 1'b0;
            prdata_q <= '0;
            slverr_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            con2_q   <= con2_d;
            din_q    <= din_d;
            ie_q     <= ie_d;
            prdata_q <= prdata_d;
            slverr_q <= slverr_d;
            irq_q    <= irq_d;
        end
    end

    apb_i2c_seq #(
        .RST_HOLD (RST_HOLD),
        .START_TO (START_TO)
    ) u_seq (
        .clk_i        (PCLK),
        .rst_ni       (PRESETn),
        .ready_i      (ready),
        .dout_i       (Dout),
        .con1_wr_i    (con1_wr),
        .con1_wdata_i (PWDATA[7:1]),
        .srst_wr_i    (srst_wr),
        .int_w1c_i    (int_w1c),
        .con1_o       (i2c_con1),
        .rx_o         (rx_w),
        .done_o       (done_w),
        .tmo_o        (tmo_w)
    );

    assign i2c_con2 = con2_q;
    assign Din      = din_q;
    assign PRDATA   = prdata_q;
    assign PSLVERR  = slverr_q;
    assign PREADY   = 1'b1;
    assign irq      = irq_q;

endmodule

// File: tb/tb_apb_i2c_regs.sv
module tb_apb_i2c_regs;

    localparam int ADDR_W   = 5;
    localparam int RST_HOLD = 16;
    localparam int START_TO = 64;

    logic              PCLK = 1'b0;
    logic              PRESETn;
    logic              PSEL, PENABLE, PWRITE;
    logic [ADDR_W-1:0] PADDR;
    logic [31:0]       PWDATA, PRDATA;
    logic              PREADY, PSLVERR;
    logic [7:0]        i2c_con1, i2c_con2, i2c_stat;
    logic [31:0]       Din, Dout;
    logic              ready, irq;

    int total = 0;
    int bad   = 0;

    always #5 PCLK = ~PCLK;

    apb_i2c_regs #(
        .ADDR_W   (ADDR_W),
        .RST_HOLD (RST_HOLD),
        .START_TO (START_TO)
    ) dut (
        .PCLK     (PCLK),
        .PRESETn  (PRESETn),
        .PSEL     (PSEL),
        .PENABLE  (PENABLE),
        .PWRITE   (PWRITE),
        .PADDR    (PADDR),
        .PWDATA   (PWDATA),
        .PRDATA   (PRDATA),
        .PREADY   (PREADY),
        .PSLVERR  (PSLVERR),
        .i2c_con1 (i2c_con1),
        .i2c_con2 (i2c_con2),
        .Din      (Din),
        .Dout     (Dout),
        .i2c_stat (i2c_stat),
        .ready    (ready),
        .irq      (irq)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge PCLK);
        #1;
    endtask

    task automatic apb(input logic w, input logic [ADDR_W-1:0] a, input logic [31:0] d,
                       output logic [31:0] r, output logic e);
        @(posedge PCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = w; PADDR = a; PWDATA = d;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        @(negedge PCLK);
        r = PRDATA;
        e = PSLVERR;
        chk("pready", 32'(PREADY), 32'd1);
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    task automatic wr(input string tag, input logic [ADDR_W-1:0] a, input logic [31:0] d,
                      input logic exp_err);
        logic [31:0] r;
        logic        e;
        apb(1'b1, a, d, r, e);
        chk({tag, "_err"}, 32'(e), 32'(exp_err));
    endtask

    task automatic rd(input string tag, input logic [ADDR_W-1:0] a, input logic [31:0] exp);
        logic [31:0] r;
        logic        e;
        apb(1'b0, a, 32'd0, r, e);
        chk(tag, r, exp);
        chk({tag, "_err"}, 32'(e), 32'd0);
    endtask

    // Reference state for the randomized phase
    logic [7:0]  m_con1, m_con2;
    logic [31:0] m_tx, m_rx;
    logic        m_done, m_tmo, m_ie;

    function automatic logic [31:0] m_read(input logic [ADDR_W-1:0] a);
        case (a)
            5'h00:   return {24'd0, m_con1};
            5'h04:   return {24'd0, m_con2};
            5'h08:   return m_tx;
            5'h0C:   return m_rx;
            5'h10:   return {23'd0, ready, i2c_stat};
            5'h14:   return {23'd0, m_ie, 6'd0, m_tmo, m_done};
            default: return 32'd0;
        endcase
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [ADDR_W-1:0] addrs [9];
        logic [31:0] r, d;
        logic        e, w, nr, exp_err, ro, rw_busy;
        int          k;

        addrs = '{5'h00, 5'h04, 5'h08, 5'h0C, 5'h10, 5'h14, 5'h18, 5'h1C, 5'h02};

        PRESETn = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        PADDR = '0; PWDATA = '0; Dout = '0; i2c_stat = '0; ready = 1'b1;
        #12;
        chk("rst_con1", 32'(i2c_con1), 32'd0);
        chk("rst_con2", 32'(i2c_con2), 32'd0);
        chk("rst_din", Din, 32'd0);
        chk("rst_prdata", PRDATA, 32'd0);
        chk("rst_pslverr", 32'(PSLVERR), 32'd0);
        chk("rst_pready", 32'(PREADY), 32'd1);
        chk("rst_irq", 32'(irq), 32'd0);
        @(negedge PCLK);
        PRESETn = 1'b1;

        rd("rst_rd_con1", 5'h00, 32'd0);
        rd("rst_rd_con2", 5'h04, 32'd0);
        rd("rst_rd_tx", 5'h08, 32'd0);
        rd("rst_rd_rx", 5'h0C, 32'd0);
        rd("rst_rd_stat", 5'h10, 32'h100);
        rd("rst_rd_int", 5'h14, 32'd0);

        // Start handshake
        wr("w_con2", 5'h04, 32'hA1, 1'b0);
        wr("w_tx", 5'h08, 32'hDEADBEEF, 1'b0);
        chk("con2_out", 32'(i2c_con2), 32'hA1);
        chk("din_out", Din, 32'hDEADBEEF);
        wr("w_con1_go", 5'h00, 32'h06, 1'b0);
        chk("con1_go", 32'(i2c_con1), 32'h06);
        cyc(4);
        chk("con1_en_held", 32'(i2c_con1), 32'h06);
        ready = 1'b0;
        cyc(1);
        chk("con1_en_autoclr", 32'(i2c_con1), 32'h04);

        wr("w_tx_busy", 5'h08, 32'h1, 1'b1);
        chk("din_kept", Din, 32'hDEADBEEF);
        wr("w_unmapped", 5'h18, 32'h20, 1'b1);
        wr("w_con2_busy", 5'h04, 32'h55, 1'b1);
        chk("con2_kept", 32'(i2c_con2), 32'hA1);
        wr("w_con1_busy", 5'h00, 32'hC0, 1'b1);
        chk("con1_kept", 32'(i2c_con1), 32'h04);
        wr("w_rx_ro", 5'h0C, 32'h1, 1'b1);
        i2c_stat = 8'h3C;
        rd("stat_busy", 5'h10, 32'h03C);
        wr("w_ie", 5'h14, 32'h100, 1'b0);
        rd("int_ie", 5'h14, 32'h100);

        // Done capture and interrupt latency
        Dout  = 32'h12345678;
        ready = 1'b1;
        cyc(1);
        chk("irq_lat0", 32'(irq), 32'd0);
        cyc(1);
        chk("irq_lat1", 32'(irq), 32'd1);
        Dout = 32'h0;
        rd("rx_cap", 5'h0C, 32'h12345678);
        rd("int_done", 5'h14, 32'h101);
        wr("w_int_clr", 5'h14, 32'h101, 1'b0);
        rd("int_clr", 5'h14, 32'h100);
        chk("irq_clr", 32'(irq), 32'd0);

        // Set wins over a coincident clear
        ready = 1'b0;
        Dout  = 32'hCAFEF00D;
        cyc(1);
        fork
            wr("w_int_race", 5'h14, 32'h101, 1'b0);
            begin cyc(2); ready = 1'b1; end
        join
        rd("int_race", 5'h14, 32'h101);
        rd("rx_race", 5'h0C, 32'hCAFEF00D);
        wr("w_int_clr2", 5'h14, 32'h101, 1'b0);
        rd("int_clr2", 5'h14, 32'h100);

        // Start timeout
        wr("w_con1_to", 5'h00, 32'h02, 1'b0);
        chk("to_en_set", 32'(i2c_con1), 32'h02);
        cyc(START_TO - 1);
        chk("to_en_last", 32'(i2c_con1), 32'h02);
        cyc(1);
        chk("to_en_clr", 32'(i2c_con1), 32'h00);
        rd("int_tmo", 5'h14, 32'h102);
        chk("irq_tmo", 32'(irq), 32'd1);
        wr("w_tmo_clr", 5'h14, 32'h002, 1'b0);
        rd("int_tmo_clr", 5'h14, 32'h000);

        // Soft-reset hold
        wr("w_srst", 5'h00, 32'h01, 1'b0);
        chk("srst_on", 32'(i2c_con1[0]), 32'd1);
        cyc(RST_HOLD - 1);
        chk("srst_last", 32'(i2c_con1[0]), 32'd1);
        cyc(1);
        chk("srst_off", 32'(i2c_con1[0]), 32'd0);
        wr("w_srst2a", 5'h00, 32'h01, 1'b0);
        cyc(7);
        wr("w_srst2b", 5'h00, 32'h01, 1'b0);
        cyc(15);
        chk("srst_ext25", 32'(i2c_con1[0]), 32'd1);
        cyc(1);
        chk("srst_ext26", 32'(i2c_con1[0]), 32'd0);

        // Busy-time soft reset applies bit0 only and masks done
        ready = 1'b0;
        cyc(1);
        wr("w_srst_busy", 5'h00, 32'hFD, 1'b0);
        chk("srst_busy_con1", 32'(i2c_con1), 32'h01);
        Dout  = 32'h77;
        ready = 1'b1;
        cyc(1);
        rd("int_masked", 5'h14, 32'h000);
        rd("rx_masked", 5'h0C, 32'hCAFEF00D);
        cyc(RST_HOLD + 2);
        chk("srst_busy_end", 32'(i2c_con1), 32'h00);

        // Reset during an access phase
        wr("w_con1_en", 5'h00, 32'h02, 1'b0);
        @(posedge PCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 5'h00;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        @(negedge PCLK);
        chk("acc_prdata", PRDATA, 32'h02);
        PRESETn = 1'b0;
        #1;
        chk("arst_con1", 32'(i2c_con1), 32'd0);
        chk("arst_prdata", PRDATA, 32'd0);
        chk("arst_pslverr", 32'(PSLVERR), 32'd0);
        chk("arst_irq", 32'(irq), 32'd0);
        PSEL = 1'b0; PENABLE = 1'b0;
        @(negedge PCLK);
        PRESETn = 1'b1;
        rd("arst_rd_con1", 5'h00, 32'd0);
        rd("arst_rd_rx", 5'h0C, 32'd0);
        rd("arst_rd_int", 5'h14, 32'd0);

        // Randomized traffic against the reference state
        m_con1 = 8'h00; m_con2 = 8'h00; m_tx = 32'd0; m_rx = 32'd0;
        m_done = 1'b0; m_tmo = 1'b0; m_ie = 1'b0;
        for (int it = 0; it < 80; it++) begin
            if ($urandom_range(3) == 0) begin
                nr = ~ready;
                Dout = $urandom;
                if (!ready && nr) begin
                    m_rx   = Dout;
                    m_done = 1'b1;
                end
                ready = nr;
            end
            i2c_stat = 8'($urandom);
            k = $urandom_range(8);
            w = 1'($urandom_range(1));
            d = $urandom;
            if (addrs[k] == 5'h00) d = d & 32'hFFFF_FFFC;
            ro      = (addrs[k] == 5'h0C) || (addrs[k] == 5'h10);
            rw_busy = (addrs[k] == 5'h00) || (addrs[k] == 5'h04) || (addrs[k] == 5'h08);
            exp_err = (k >= 6) || (w && ro) || (w && rw_busy && !ready);
            apb(w, addrs[k], d, r, e);
            chk("rnd_err", 32'(e), 32'(exp_err));
            if (!w && k < 6) begin
                chk("rnd_rd", r, m_read(addrs[k]));
            end
            if (w && !exp_err) begin
                case (addrs[k])
                    5'h00: m_con1 = d[7:0];
                    5'h04: m_con2 = d[7:0];
                    5'h08: m_tx   = d;
                    5'h14: begin
                        if (d[0]) m_done = 1'b0;
                        if (d[1]) m_tmo  = 1'b0;
                        m_ie = d[8];
                    end
                    default: ;
                endcase
            end
            cyc(1);
            chk("rnd_con1", 32'(i2c_con1), 32'(m_con1));
            chk("rnd_con2", 32'(i2c_con2), 32'(m_con2));
            chk("rnd_din", Din, m_tx);
            chk("rnd_irq", 32'(irq), 32'(m_ie & (m_done | m_tmo)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
